// File: rtl/bufram_fill_pkg.sv
// Shared encodings for the bufram fill engine: FSM states and port-B byte enables.
package bufram_fill_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] FILL = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Big-endian packing: even halfword to the upper lanes, odd to the lower.
  localparam logic [3:0] WE_HI   = 4'b1100;
  localparam logic [3:0] WE_LO   = 4'b0011;
  localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/bufram_fill_ctr.sv
// Halfword counter for one line fill; wraps naturally and flags the last halfword.
module bufram_fill_ctr #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             tc_c
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + WIDTH'(1);
  end

  assign tc_c = (cnt == {WIDTH{1'b1}});

endmodule

// File: rtl/bufram_fill.sv
// SDRAM-side line fill engine: one burst read per request, halfwords packed into bufram port B.
// Optional critical-word-first ordering via `define BUFRAM_FILL_CRITICAL_WORD_FIRST_EN.
module bufram_fill
  import bufram_fill_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  sdram_clk,
  input  logic                  sdram_rst,
  input  logic                  fill_req_i,
  input  logic [31:0]           fill_adr_i,
  output logic                  fill_busy_o,
  output logic                  fill_done_o,
  output logic                  sdram_req_o,
  output logic [31:0]           sdram_adr_o,
  input  logic                  sdram_ack_i,
  input  logic                  sdram_dv_i,
  input  logic [15:0]           sdram_dat_i,
`ifdef BUFRAM_FILL_CRITICAL_WORD_FIRST_EN
  output logic                  crit_valid_o,
`endif
  output logic [ADDR_WIDTH-1:0] buf_addr_o,
  output logic [3:0]            buf_we_o,
  output logic [31:0]           buf_di_o
);

  localparam int unsigned HW = ADDR_WIDTH + 1;

  logic [1:0]            state, state_nxt;
  logic [HW-1:0]         hcnt;
  logic                  tc_c;
  logic                  wr_c;
  logic                  start_c;
  logic [ADDR_WIDTH-1:0] start_word;
  logic [31:0]           adr_aligned_c;

  logic                  busy_nxt, done_nxt, req_nxt;
  logic [31:0]           adr_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [3:0]            we_nxt;
  logic [31:0]           di_nxt;
`ifdef BUFRAM_FILL_CRITICAL_WORD_FIRST_EN
  logic                  crit_nxt;
  logic [ADDR_WIDTH-1:0] start_word_q;
  logic                  unused_adr;

  assign adr_aligned_c = {fill_adr_i[31:2], 2'b00};
  assign start_word    = start_word_q;
  assign unused_adr    = ^fill_adr_i[1:0];

  // Requested word index is captured with the request so writes start there.
  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst)    start_word_q <= '0;
    else if (start_c) start_word_q <= fill_adr_i[ADDR_WIDTH+1:2];
  end
`else
  logic                  unused_adr;

  assign adr_aligned_c = {fill_adr_i[31:ADDR_WIDTH+2], (ADDR_WIDTH+2)'(0)};
  assign start_word    = '0;
  assign unused_adr    = ^fill_adr_i[ADDR_WIDTH+1:0];
`endif

  assign start_c = (state == IDLE) && fill_req_i;
  assign wr_c    = (state == FILL) && sdram_dv_i;

  bufram_fill_ctr #(.WIDTH(HW)) u_ctr (
    .clk  (sdram_clk),
    .rst  (sdram_rst),
    .clr  (state == IDLE),
    .inc  (wr_c),
    .cnt  (hcnt),
    .tc_c (tc_c)
  );

  // State register plus the registered outputs.
  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      state        <= IDLE;
      fill_busy_o  <= 1'b0;
      fill_done_o  <= 1'b0;
      sdram_req_o  <= 1'b0;
      sdram_adr_o  <= '0;
      buf_addr_o   <= '0;
      buf_we_o     <= WE_NONE;
      buf_di_o     <= '0;
`ifdef BUFRAM_FILL_CRITICAL_WORD_FIRST_EN
      crit_valid_o <= 1'b0;
`endif
    end else begin
      state        <= state_nxt;
      fill_busy_o  <= busy_nxt;
      fill_done_o  <= done_nxt;
      sdram_req_o  <= req_nxt;
      sdram_adr_o  <= adr_nxt;
      buf_addr_o   <= addr_nxt;
      buf_we_o     <= we_nxt;
      buf_di_o     <= di_nxt;
`ifdef BUFRAM_FILL_CRITICAL_WORD_FIRST_EN
      crit_valid_o <= crit_nxt;
`endif
    end
  end

  // Next state; dv outside FILL and requests while busy are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fill_req_i) state_nxt = REQ;
      REQ:     if (sdram_ack_i) state_nxt = FILL;
      FILL:    if (wr_c && tc_c) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
    req_nxt  = (state_nxt == REQ);
    adr_nxt  = sdram_adr_o;
    addr_nxt = buf_addr_o;
    we_nxt   = WE_NONE;
    di_nxt   = buf_di_o;
`ifdef BUFRAM_FILL_CRITICAL_WORD_FIRST_EN
    crit_nxt = wr_c && (hcnt == HW'(1));
`endif
    if (start_c) adr_nxt = adr_aligned_c;
    if (wr_c) begin
      addr_nxt = ADDR_WIDTH'(hcnt[HW-1:1] + start_word);
      we_nxt   = hcnt[0] ? WE_LO : WE_HI;
      di_nxt   = {sdram_dat_i, sdram_dat_i};
    end
  end

endmodule
